// File: rtl/fsm_key_ctrl_pkg.sv
// fsm_key_ctrl_pkg
//   Shared types and helpers for the key-load / run sequencer.
//   - ctrl_state_e : sequencer states
//   - DEF_*        : default parameter values for the top level
//   - cntWidth()   : bits needed to hold the values 0..maxVal
package fsm_key_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETTLE,
    RUN,
    LOCKOUT
  } ctrl_state_e;

  localparam int DEF_KEY_W      = 1;
  localparam int DEF_FAIL_MAX   = 3;
  localparam int DEF_SETTLE_CYC = 2;

  // Width of a counter that must reach maxVal itself (not just maxVal-1).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/fsm_key_ctrl_if.sv
// fsm_key_ctrl_if
//   Bundles the key-loading inputs and the controlled-FSM outputs of
//   fsm_key_ctrl.
//   Inputs to the sequencer : key_sdi, key_sen, key_commit, key_par, run_req
//   Outputs from sequencer  : keyinput[KEY_W], dut_rst, dut_en, busy, err, locked
//   master : the side that loads keys and observes status
//   slave  : the sequencer itself
interface fsm_key_ctrl_if #(
  parameter int KEY_W = 1
) ();

  logic             key_sdi;
  logic             key_sen;
  logic             key_commit;
  logic             key_par;
  logic             run_req;
  logic [KEY_W-1:0] keyinput;
  logic             dut_rst;
  logic             dut_en;
  logic             busy;
  logic             err;
  logic             locked;

  modport master (
    output key_sdi, key_sen, key_commit, key_par, run_req,
    input  keyinput, dut_rst, dut_en, busy, err, locked
  );

  modport slave (
    input  key_sdi, key_sen, key_commit, key_par, run_req,
    output keyinput, dut_rst, dut_en, busy, err, locked
  );

endinterface

// File: rtl/fsm_key_ctrl_key_shift_reg.sv
// key_shift_reg
//   Serial key shift register (MSB first) with a saturating bit counter.
//   clk      : clock
//   rst      : synchronous active-high reset
//   shift_i  : shift sdi_i into the register this cycle
//   clear_i  : restart the bit count; with shift_i the count restarts at 1
//   sdi_i    : serial key bit
//   shreg_o  : current register contents
//   full_o   : KEY_W bits shifted since the last clear
module key_shift_reg
  import fsm_key_ctrl_pkg::*;
#(
  parameter int KEY_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic             sdi_i,
  output logic [KEY_W-1:0] shreg_o,
  output logic             full_o
);

  localparam int BIT_W = cntWidth(KEY_W);
  localparam logic [BIT_W-1:0] CNT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] CNT_FULL = BIT_W'(KEY_W);

  logic [KEY_W-1:0] shreg_q;
  logic [KEY_W-1:0] shreg_d;
  logic [BIT_W-1:0] bitCnt_q;

  // A one-bit key simply takes the new bit; wider keys shift left.
  if (KEY_W == 1) begin : g_narrow
    assign shreg_d = sdi_i;
  end else begin : g_wide
    assign shreg_d = {shreg_q[KEY_W-2:0], sdi_i};
  end

  // The count saturates at KEY_W so extra bits keep the register full
  // while the oldest bits fall off the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      bitCnt_q <= '0;
    end else begin
      if (shift_i) begin
        shreg_q <= shreg_d;
      end
      if (clear_i) begin
        bitCnt_q <= shift_i ? CNT_ONE : '0;
      end else if (shift_i && (bitCnt_q != CNT_FULL)) begin
        bitCnt_q <= bitCnt_q + CNT_ONE;
      end
    end
  end

  assign shreg_o = shreg_q;
  assign full_o  = (bitCnt_q == CNT_FULL);

endmodule

// File: rtl/fsm_key_ctrl.sv
// fsm_key_ctrl
//   Key-load and run sequencer for a key-locked benchmark FSM. A serial key
//   is shifted in, a commit applies it to keyinput, the controlled FSM is
//   held in reset for SETTLE_CYC cycles, and then run_req gates dut_en.
//   FAIL_MAX consecutive bad commits lock the block until rst.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fsm_key_ctrl_if slave (key inputs, run_req, all outputs)
//   Optional feature macro KEY_PARITY_EN: a commit must also match key_par
//   against the parity of the shifted key.
module fsm_key_ctrl
  import fsm_key_ctrl_pkg::*;
#(
  parameter int KEY_W      = DEF_KEY_W,
  parameter int FAIL_MAX   = DEF_FAIL_MAX,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic          clk,
  input  logic          rst,
  fsm_key_ctrl_if.slave bus
);

  localparam int FAIL_W   = cntWidth(FAIL_MAX);
  localparam int SETTLE_W = cntWidth(SETTLE_CYC);
  localparam logic [FAIL_W-1:0]   FAIL_ONE   = FAIL_W'(1);
  localparam logic [FAIL_W-1:0]   FAIL_LAST  = FAIL_W'(FAIL_MAX - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE_CYC);

  ctrl_state_e         state_q;
  logic [FAIL_W-1:0]   failCnt_q;
  logic [SETTLE_W-1:0] settleCnt_q;
  logic [KEY_W-1:0]    keyinput_q;
  logic                dutRst_q;
  logic                dutEn_q;
  logic                busy_q;
  logic                err_q;
  logic                locked_q;

  logic [KEY_W-1:0]    shreg;
  logic                keyFull;
  logic                parityOk;
  logic                commitGood;
  logic                shiftEn;
  logic                clearEn;

`ifdef KEY_PARITY_EN
  assign parityOk = ((^shreg) == bus.key_par);
`else
  logic unusedKeyPar;
  assign unusedKeyPar = bus.key_par;
  assign parityOk     = 1'b1;
`endif

  assign commitGood = keyFull && parityOk;

  // Shift-register control. Entering SHIFT from IDLE or RUN restarts the
  // count with the incoming bit; a commit in SHIFT suppresses the shift,
  // and a bad commit discards the partial count.
  always_comb begin
    shiftEn = 1'b0;
    clearEn = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        shiftEn = bus.key_sen;
        clearEn = bus.key_sen;
      end
      SHIFT: begin
        shiftEn = bus.key_sen && !bus.key_commit;
        clearEn = bus.key_commit && !commitGood;
      end
      default: begin
        shiftEn = 1'b0;
        clearEn = 1'b0;
      end
    endcase
  end

  key_shift_reg #(
    .KEY_W(KEY_W)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .shift_i(shiftEn),
    .clear_i(clearEn),
    .sdi_i  (bus.key_sdi),
    .shreg_o(shreg),
    .full_o (keyFull)
  );

  // Sequencer state and every output are registered together so each
  // output always describes the state being entered on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      failCnt_q   <= '0;
      settleCnt_q <= '0;
      keyinput_q  <= '0;
      dutRst_q    <= 1'b1;
      dutEn_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.key_sen) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.key_commit) begin
            if (commitGood) begin
              state_q     <= SETTLE;
              keyinput_q  <= shreg;
              failCnt_q   <= '0;
              settleCnt_q <= SETTLE_LD;
            end else begin
              err_q     <= 1'b1;
              busy_q    <= 1'b0;
              failCnt_q <= failCnt_q + FAIL_ONE;
              if (failCnt_q == FAIL_LAST) begin
                state_q    <= LOCKOUT;
                locked_q   <= 1'b1;
                keyinput_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        SETTLE: begin
          // Reaching 1 here puts the release exactly SETTLE_CYC edges
          // after the commit edge.
          if (settleCnt_q == SETTLE_ONE) begin
            state_q  <= RUN;
            dutRst_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            settleCnt_q <= settleCnt_q - SETTLE_ONE;
          end
        end
        RUN: begin
          if (bus.key_sen) begin
            state_q    <= SHIFT;
            keyinput_q <= '0;
            dutRst_q   <= 1'b1;
            dutEn_q    <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            dutEn_q <= bus.run_req;
          end
        end
        LOCKOUT: begin
          state_q <= LOCKOUT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.keyinput = keyinput_q;
  assign bus.dut_rst  = dutRst_q;
  assign bus.dut_en   = dutEn_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_fsm_key_ctrl.sv
// tb_fsm_key_ctrl
//   Self-checking bench for fsm_key_ctrl with KEY_W=4, FAIL_MAX=3,
//   SETTLE_CYC=2. A behavioural model tracks the key history as an integer,
//   counts bits and failures, and predicts every output each cycle.
//   Honours KEY_PARITY_EN the same way as the design.
module tb_fsm_key_ctrl;

  localparam int KEY_W      = 4;
  localparam int FAIL_MAX   = 3;
  localparam int SETTLE_CYC = 2;

  localparam int M_IDLE   = 0;
  localparam int M_SHIFT  = 1;
  localparam int M_SETTLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_LOCK   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fsm_key_ctrl_if #(.KEY_W(KEY_W)) bus ();

  fsm_key_ctrl #(
    .KEY_W     (KEY_W),
    .FAIL_MAX  (FAIL_MAX),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compareCount  = 0;
  int mismatchCount = 0;

  int               mMode   = M_IDLE;
  int               mCount  = 0;
  int               mFails  = 0;
  int               mSettle = 0;
  logic [KEY_W-1:0] mShift  = '0;
  logic [KEY_W-1:0] mKey    = '0;
  bit               mErr    = 1'b0;
  bit               mEn     = 1'b0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Reference behaviour for one clock edge given the inputs held across it.
  task automatic modelStep(input bit sen, input bit sdi, input bit commit,
                           input bit par, input bit runReq, input bit rstIn);
    bit ok;
    mErr = 1'b0;
    if (rstIn) begin
      mMode = M_IDLE; mCount = 0; mFails = 0; mSettle = 0;
      mShift = '0; mKey = '0; mEn = 1'b0;
      return;
    end
    case (mMode)
      M_IDLE: if (sen) begin
        mShift = (mShift << 1) | KEY_W'(sdi);
        mCount = 1;
        mMode  = M_SHIFT;
      end
      M_SHIFT: begin
        if (commit) begin
          ok = (mCount >= KEY_W);
`ifdef KEY_PARITY_EN
          ok = ok && (($countones(mShift) % 2) == int'(par));
`endif
          if (ok) begin
            mKey    = mShift;
            mFails  = 0;
            mSettle = SETTLE_CYC;
            mMode   = M_SETTLE;
          end else begin
            mErr   = 1'b1;
            mFails = mFails + 1;
            mCount = 0;
            mMode  = (mFails == FAIL_MAX) ? M_LOCK : M_IDLE;
          end
        end else if (sen) begin
          mShift = (mShift << 1) | KEY_W'(sdi);
          mCount = mCount + 1;
        end
      end
      M_SETTLE: begin
        if (mSettle == 1) mMode = M_RUN;
        else mSettle = mSettle - 1;
      end
      M_RUN: begin
        if (sen) begin
          mKey   = '0;
          mEn    = 1'b0;
          mShift = (mShift << 1) | KEY_W'(sdi);
          mCount = 1;
          mMode  = M_SHIFT;
        end else begin
          mEn = runReq;
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkAllOutputs(input string tag);
    checkOutput({tag, ".keyinput"}, 32'(bus.keyinput), 32'(mKey));
    checkOutput({tag, ".dut_rst"}, 32'(bus.dut_rst), 32'(mMode != M_RUN));
    checkOutput({tag, ".dut_en"}, 32'(bus.dut_en), 32'(mEn && (mMode == M_RUN)));
    checkOutput({tag, ".busy"}, 32'(bus.busy),
                32'((mMode == M_SHIFT) || (mMode == M_SETTLE)));
    checkOutput({tag, ".err"}, 32'(bus.err), 32'(mErr));
    checkOutput({tag, ".locked"}, 32'(bus.locked), 32'(mMode == M_LOCK));
  endtask

  // Drives one cycle of inputs, advances the model, and checks after the edge.
  task automatic applyStimulus(input string tag, input bit sen, input bit sdi,
                               input bit commit, input bit par,
                               input bit runReq, input bit rstIn);
    rst            = rstIn;
    bus.key_sen    = sen;
    bus.key_sdi    = sdi;
    bus.key_commit = commit;
    bus.key_par    = par;
    bus.run_req    = runReq;
    modelStep(sen, sdi, commit, par, runReq, rstIn);
    @(posedge clk);
    #1;
    checkAllOutputs(tag);
  endtask

  task automatic shiftKey(input string tag, input logic [3:0] key);
    logic [3:0] k;
    k = key;
    for (int b = 3; b >= 0; b--) applyStimulus(tag, 1, k[b], 0, 0, 0, 0);
  endtask

  initial begin
    bus.key_sen = 0; bus.key_sdi = 0; bus.key_commit = 0;
    bus.key_par = 0; bus.run_req = 0;

    // Reset values
    applyStimulus("reset", 0, 0, 0, 0, 0, 1);
    checkOutput("reset.dut_rst_abs", 32'(bus.dut_rst), 32'd1);

    // Good load of 1011, settle, release
    shiftKey("t1_shift", 4'b1011);
    applyStimulus("t1_commit", 0, 0, 1, 1, 0, 0);
    checkOutput("t1_key_abs", 32'(bus.keyinput), 32'hB);
    applyStimulus("t1_settle1", 0, 0, 0, 0, 0, 0);
    checkOutput("t1_rst_held", 32'(bus.dut_rst), 32'd1);
    applyStimulus("t1_settle2", 0, 0, 0, 0, 0, 0);
    checkOutput("t1_rst_low", 32'(bus.dut_rst), 32'd0);
    checkOutput("t1_busy_low", 32'(bus.busy), 32'd0);

    // Run enable then rekey
    applyStimulus("t3_run", 0, 0, 0, 0, 1, 0);
    checkOutput("t3_en_abs", 32'(bus.dut_en), 32'd1);
    applyStimulus("t3_rekey", 1, 0, 0, 0, 1, 0);
    checkOutput("t3_rekey_key", 32'(bus.keyinput), 32'd0);
    checkOutput("t3_rekey_busy", 32'(bus.busy), 32'd1);

    // Three short commits lock the block
    applyStimulus("t2_bit2", 1, 1, 0, 0, 0, 0);
    applyStimulus("t2_bad1", 0, 0, 1, 0, 0, 0);
    checkOutput("t2_err1_abs", 32'(bus.err), 32'd1);
    for (int n = 0; n < 2; n++) begin
      applyStimulus("t2_shift", 1, 1, 0, 0, 0, 0);
      applyStimulus("t2_shift", 1, 0, 0, 0, 0, 0);
      applyStimulus("t2_bad", 0, 0, 1, 0, 0, 0);
    end
    checkOutput("t2_locked_abs", 32'(bus.locked), 32'd1);
    for (int n = 0; n < 6; n++) applyStimulus("t2_ignored", 1, 1, n[0], 0, 1, 0);

    // Commit wins over a simultaneous shift
    applyStimulus("t4_reset", 0, 0, 0, 0, 0, 1);
    shiftKey("t4_shift", 4'b1100);
    applyStimulus("t4_commit", 1, 1, 1, 0, 0, 0);
    checkOutput("t4_key_abs", 32'(bus.keyinput), 32'hC);

    // Reset during SETTLE, then reset clears the failure count
    applyStimulus("t5_rst", 0, 0, 0, 0, 0, 1);
    checkOutput("t5_busy_abs", 32'(bus.busy), 32'd0);
    for (int n = 0; n < 2; n++) begin
      applyStimulus("t5_shift", 1, 0, 0, 0, 0, 0);
      applyStimulus("t5_bad", 0, 0, 1, 0, 0, 0);
    end
    applyStimulus("t5_shift", 1, 0, 0, 0, 0, 0);
    applyStimulus("t5_rst2", 0, 0, 0, 0, 0, 1);
    applyStimulus("t5_shift", 1, 0, 0, 0, 0, 0);
    applyStimulus("t5_bad", 0, 0, 1, 0, 0, 0);
    checkOutput("t5_not_locked", 32'(bus.locked), 32'd0);

`ifdef KEY_PARITY_EN
    applyStimulus("t6_reset", 0, 0, 0, 0, 0, 1);
    shiftKey("t6_shift", 4'b1011);
    applyStimulus("t6_badpar", 0, 0, 1, 0, 0, 0);
    checkOutput("t6_err_abs", 32'(bus.err), 32'd1);
    shiftKey("t6_shift2", 4'b1011);
    applyStimulus("t6_goodpar", 0, 0, 1, 1, 0, 0);
    checkOutput("t6_busy_abs", 32'(bus.busy), 32'd1);
`endif

    // Randomized traffic against the model
    applyStimulus("rnd_reset", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount,
             mismatchCount);
    $finish;
  end

endmodule
